// File: rtl/can_bit_destuffer.sv
// CAN receive-side bit destuffer: strips stuff bits, flags six-equal-bit
// violations and packs destuffed bits MSB-first into WORD_W-bit words.
module can_bit_destuffer #(
  parameter int WORD_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              frame_end,
  input  logic              sample_valid,
  input  logic              rx_bit,
  output logic              bit_valid,
  output logic              bit_out,
  output logic              stuff_drop,
  output logic              stuff_err,
  output logic              word_valid,
  output logic [WORD_W-1:0] data_out,
  output logic [6:0]        word_len,
  output logic              busy
);

  localparam int CNT_W = $clog2(WORD_W) + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_W);

  typedef enum logic [1:0] {IDLE, ACTIVE, ERROR} state_t;

  state_t            state, state_nxt;
  logic [2:0]        run_len, run_cur, run_nxt;
  logic              last_bit;
  logic [WORD_W-1:0] shreg, shreg_nxt, flush_mask;
  logic [CNT_W-1:0]  bit_cnt, cnt_cur, cnt_inc, cnt_nxt;
  logic              proc_en, is_stuff, is_err, is_data;
  logic              word_full, do_end, do_flush;

  // frame_start zeroes run and count before a same-cycle sample is judged,
  // so the SOF bit can never be mistaken for a stuff bit.
  always_comb begin
    run_cur    = frame_start ? 3'd0 : run_len;
    cnt_cur    = frame_start ? '0 : bit_cnt;
    proc_en    = sample_valid && (frame_start || state == ACTIVE);
    is_stuff   = proc_en && (run_cur == 3'd5) && (rx_bit != last_bit);
    is_err     = proc_en && (run_cur == 3'd5) && (rx_bit == last_bit);
    is_data    = proc_en && (run_cur != 3'd5);
    shreg_nxt  = is_data ? {shreg[WORD_W-2:0], rx_bit} : shreg;
    cnt_inc    = cnt_cur + CNT_W'(1);
    word_full  = is_data && (cnt_inc == CNT_FULL);
    cnt_nxt    = is_data ? (word_full ? '0 : cnt_inc) : cnt_cur;
    do_end     = frame_end && (state == ACTIVE) && !frame_start && !is_err;
    do_flush   = do_end && (cnt_nxt != '0);
    flush_mask = ~({WORD_W{1'b1}} << cnt_nxt);
    run_nxt    = ((rx_bit == last_bit) && (run_cur != 3'd0)) ? run_cur + 3'd1 : 3'd1;
    state_nxt  = state;
    if (frame_start)  state_nxt = ACTIVE;
    else if (is_err)  state_nxt = ERROR;
    else if (do_end)  state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      run_len    <= 3'd0;
      last_bit   <= 1'b0;
      shreg      <= '0;
      bit_cnt    <= '0;
      bit_valid  <= 1'b0;
      bit_out    <= 1'b0;
      stuff_drop <= 1'b0;
      stuff_err  <= 1'b0;
      word_valid <= 1'b0;
      data_out   <= '0;
      word_len   <= 7'd0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      busy       <= (state_nxt == ACTIVE);
      bit_valid  <= is_data;
      stuff_drop <= is_stuff;
      word_valid <= word_full || do_flush;
      shreg      <= shreg_nxt;
      bit_cnt    <= do_end ? '0 : cnt_nxt;

      if (is_data)       run_len <= run_nxt;
      else if (is_stuff) run_len <= 3'd1;
      else               run_len <= run_cur;

      if (is_data) bit_out <= rx_bit;
      if (is_data || is_stuff) last_bit <= rx_bit;

      if (frame_start) stuff_err <= 1'b0;
      else if (is_err) stuff_err <= 1'b1;

      // A 64th bit takes precedence; the count is then zero so no flush follows.
      if (word_full) begin
        data_out <= shreg_nxt;
        word_len <= 7'(WORD_W);
      end else if (do_flush) begin
        data_out <= shreg_nxt & flush_mask;
        word_len <= 7'(cnt_nxt);
      end
    end
  end

endmodule

// File: tb/tb_can_bit_destuffer.sv
// Scoreboard bench for can_bit_destuffer: expected bits and words are queued
// as stimulus is driven and checked by a monitor as the DUT emits them.
module tb_can_bit_destuffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_start, frame_end, sample_valid, rx_bit;
  logic        bit_valid, bit_out, stuff_drop, stuff_err, word_valid, busy;
  logic [63:0] data_out;
  logic [6:0]  word_len;

  int vectors = 0;
  int miscompares = 0;
  int n_bits = 0;
  int n_drops = 0;
  int n_words = 0;

  logic        exp_bits[$];
  logic [63:0] exp_data[$];
  logic [6:0]  exp_len[$];

  can_bit_destuffer #(.WORD_W(64)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .frame_end(frame_end),
    .sample_valid(sample_valid), .rx_bit(rx_bit), .bit_valid(bit_valid),
    .bit_out(bit_out), .stuff_drop(stuff_drop), .stuff_err(stuff_err),
    .word_valid(word_valid), .data_out(data_out), .word_len(word_len), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Monitor: every emitted bit/word must match the head of its queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bit_valid) begin
        n_bits++;
        vectors++;
        if (exp_bits.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL unexpected_bit: got bit %0b, expected none", bit_out);
        end else begin
          logic e;
          e = exp_bits.pop_front();
          if (bit_out !== e) begin
            miscompares++;
            $display("[TB] FAIL bit_out: got %0b, expected %0b", bit_out, e);
          end
        end
      end
      if (stuff_drop) n_drops++;
      if (word_valid) begin
        n_words++;
        vectors++;
        if (exp_data.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL unexpected_word: got %h len %0d, expected none", data_out, word_len);
        end else begin
          logic [63:0] ed;
          logic [6:0]  el;
          ed = exp_data.pop_front();
          el = exp_len.pop_front();
          if (data_out !== ed || word_len !== el) begin
            miscompares++;
            $display("[TB] FAIL word: got %h len %0d, expected %h len %0d", data_out, word_len, ed, el);
          end
        end
      end
    end
  end

  task automatic apply_stimulus(input logic fs, input logic sv, input logic b, input logic fe);
    frame_start  = fs;
    sample_valid = sv;
    rx_bit       = b;
    frame_end    = fe;
    @(posedge clk);
    #1;
    frame_start  = 1'b0;
    sample_valid = 1'b0;
    rx_bit       = 1'b0;
    frame_end    = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_counts();
    n_bits = 0;
    n_drops = 0;
    n_words = 0;
  endtask

  task automatic check_counts(input string name, input int eb, input int ed, input int ew);
    vectors++;
    if (n_bits != eb || n_drops != ed || n_words != ew || exp_bits.size() != 0 || exp_data.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL %s_counts: got bits=%0d drops=%0d words=%0d pending=%0d/%0d, expected %0d/%0d/%0d pending 0/0",
               name, n_bits, n_drops, n_words, exp_bits.size(), exp_data.size(), eb, ed, ew);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    frame_start = 0; frame_end = 0; sample_valid = 0; rx_bit = 0;
    #13;
    vectors++;
    if ({bit_valid, bit_out, stuff_drop, stuff_err, word_valid, busy} !== 6'b0 ||
        data_out !== 64'd0 || word_len !== 7'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got flags=%b data=%h len=%0d, expected all 0",
               {bit_valid, bit_out, stuff_drop, stuff_err, word_valid, busy}, data_out, word_len);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(2);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL idle_busy: got %0b, expected 0", busy);
    end
  endtask

  task automatic test_stuff_removal();
    logic [7:0] stim;
    logic [6:0] dat;
    stim = 8'b00000110;
    dat  = 7'b0000010;
    start_counts();
    for (int i = 6; i >= 0; i--) exp_bits.push_back(dat[i]);
    exp_data.push_back(64'h2);
    exp_len.push_back(7'd7);
    apply_stimulus(1, 0, 0, 0);
    for (int i = 7; i >= 0; i--) begin
      apply_stimulus(0, 1, stim[i], 0);
      if (i == 2) begin
        vectors++;
        if (stuff_drop !== 1'b1 || bit_valid !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL drop_6th: got drop=%0b valid=%0b, expected drop=1 valid=0", stuff_drop, bit_valid);
        end
      end
    end
    apply_stimulus(0, 0, 0, 1);
    idle_cycles(2);
    check_counts("stuff_removal", 7, 1, 1);
  endtask

  task automatic test_stuff_new_run();
    logic [10:0] stim;
    logic [8:0]  dat;
    stim = 11'b11111_0_0000_1;
    dat  = 9'b111110000;
    start_counts();
    for (int i = 8; i >= 0; i--) exp_bits.push_back(dat[i]);
    exp_data.push_back(64'h1F0);
    exp_len.push_back(7'd9);
    apply_stimulus(1, 0, 0, 0);
    for (int i = 10; i >= 0; i--) apply_stimulus(0, 1, stim[i], 0);
    vectors++;
    if (stuff_err !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL new_run_state: got err=%0b busy=%0b, expected err=0 busy=1", stuff_err, busy);
    end
    apply_stimulus(0, 0, 0, 1);
    idle_cycles(2);
    check_counts("stuff_new_run", 9, 2, 1);
  endtask

  task automatic test_stuff_error();
    start_counts();
    for (int i = 0; i < 5; i++) exp_bits.push_back(1'b0);
    apply_stimulus(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) apply_stimulus(0, 1, 0, 0);
    vectors++;
    if (stuff_err !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL stuff_error: got err=%0b busy=%0b, expected err=1 busy=0", stuff_err, busy);
    end
    for (int i = 0; i < 3; i++) apply_stimulus(0, 1, i[0], 0);
    apply_stimulus(0, 0, 0, 1);
    idle_cycles(2);
    vectors++;
    if (stuff_err !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL err_sticky: got %0b, expected 1", stuff_err);
    end
    check_counts("stuff_error", 5, 0, 0);
    apply_stimulus(1, 0, 0, 0);
    vectors++;
    if (stuff_err !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL err_clear: got err=%0b busy=%0b, expected err=0 busy=1", stuff_err, busy);
    end
    apply_stimulus(0, 0, 0, 1);
    idle_cycles(2);
    check_counts("err_restart", 5, 0, 0);
  endtask

  task automatic test_full_word();
    start_counts();
    for (int i = 0; i < 64; i++) exp_bits.push_back(~i[0]);
    exp_data.push_back(64'hAAAA_AAAA_AAAA_AAAA);
    exp_len.push_back(7'd64);
    apply_stimulus(1, 0, 0, 0);
    for (int i = 0; i < 64; i++) apply_stimulus(0, 1, ~i[0], 0);
    idle_cycles(1);
    apply_stimulus(0, 0, 0, 1);
    idle_cycles(2);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL full_word_busy: got %0b, expected 0", busy);
    end
    check_counts("full_word", 64, 0, 1);
  endtask

  task automatic test_simultaneous();
    start_counts();
    for (int i = 0; i < 5; i++) exp_bits.push_back(1'b0);
    exp_data.push_back(64'h0);
    exp_len.push_back(7'd5);
    apply_stimulus(1, 1, 0, 0);
    for (int i = 0; i < 4; i++) apply_stimulus(0, 1, 0, 0);
    apply_stimulus(0, 1, 1, 0);
    apply_stimulus(0, 0, 0, 1);
    idle_cycles(2);
    check_counts("start_with_sample", 5, 1, 0 + 1);

    start_counts();
    exp_bits.push_back(1'b1); exp_bits.push_back(1'b0); exp_bits.push_back(1'b1);
    exp_data.push_back(64'h5);
    exp_len.push_back(7'd3);
    apply_stimulus(1, 0, 0, 0);
    apply_stimulus(0, 1, 1, 0);
    apply_stimulus(0, 1, 0, 0);
    apply_stimulus(0, 1, 1, 1);
    vectors++;
    if (word_valid !== 1'b1 || word_len !== 7'd3) begin
      miscompares++;
      $display("[TB] FAIL end_with_3rd: got valid=%0b len=%0d, expected valid=1 len=3", word_valid, word_len);
    end
    idle_cycles(2);
    check_counts("end_with_3rd", 3, 0, 1);
  endtask

  task automatic test_back_to_back();
    start_counts();
    for (int i = 0; i < 64; i++) exp_bits.push_back(i[0]);
    exp_data.push_back(64'h5555_5555_5555_5555);
    exp_len.push_back(7'd64);
    apply_stimulus(1, 0, 0, 0);
    for (int i = 0; i < 63; i++) apply_stimulus(0, 1, i[0], 0);
    apply_stimulus(0, 1, 1, 1);
    idle_cycles(3);
    check_counts("word64_with_end", 64, 0, 1);
  endtask

  task automatic test_async_reset();
    start_counts();
    for (int i = 0; i < 10; i++) exp_bits.push_back(~i[0]);
    apply_stimulus(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) apply_stimulus(0, 1, ~i[0], 0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bit_valid, bit_out, stuff_drop, stuff_err, word_valid, busy} !== 6'b0 ||
        data_out !== 64'd0 || word_len !== 7'd0) begin
      miscompares++;
      $display("[TB] FAIL async_reset: got flags=%b data=%h len=%0d, expected all 0",
               {bit_valid, bit_out, stuff_drop, stuff_err, word_valid, busy}, data_out, word_len);
    end
    #4;
    rst_n = 1'b1;
    idle_cycles(1);
    for (int i = 0; i < 4; i++) apply_stimulus(0, 1, 1, 0);
    apply_stimulus(0, 0, 0, 1);
    idle_cycles(2);
    check_counts("post_reset_idle", 10, 0, 0);

    exp_bits.push_back(1'b1); exp_bits.push_back(1'b1); exp_bits.push_back(1'b0);
    exp_data.push_back(64'h6);
    exp_len.push_back(7'd3);
    apply_stimulus(1, 0, 0, 0);
    apply_stimulus(0, 1, 1, 0);
    apply_stimulus(0, 1, 1, 0);
    apply_stimulus(0, 1, 0, 0);
    apply_stimulus(0, 0, 0, 1);
    idle_cycles(2);
    check_counts("post_reset_frame", 13, 0, 1);
  endtask

  initial begin
    test_reset();
    test_stuff_removal();
    test_stuff_new_run();
    test_stuff_error();
    test_full_word();
    test_simultaneous();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
